user_gio_pwm_multi: RTL and testbench
=====================================

USER_GIO_PWM_MULTI -- requirements
Module: user_gio_pwm_multi

Interface
REQ-001 SHALL have parameter NCH, default 18: number of PWM channels, range 1..24.
REQ-002 SHALL have parameter CW, default 16: counter, period and duty width, range 4..32.
REQ-003 SHALL have parameter AW, default 5: word-address width; NCH <= 2^AW - 8.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk_clk and reset_reset_n.
REQ-005 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset_reset_n  in  1  asynchronous assert, active-low.
REQ-007 avs_address  in  AW  Avalon-MM word address.
REQ-008 avs_write  in  1  write strobe.
REQ-009 avs_writedata  in  32  write data.
REQ-010 avs_read  in  1  read strobe.
REQ-011 avs_readdata  out  32  read data, fixed read latency 1; no waitrequest.
REQ-012 irq  out  1  level interrupt, period-wrap.
REQ-013 pwm_export  out  NCH  channel outputs; bit i drives channel i.

Function
REQ-014 Register map, by word address:
- 0x0 CTRL: [0] RUN; [1] INV; [2] IRQ_EN.
- 0x1 PERIOD: [CW-1:0] shadow.
- 0x2 PRESCALE: [15:0] shadow.
- 0x3 CH_EN: [NCH-1:0].
- 0x4 COUNT: read-only.
- 0x5 STATUS: [0] WRAP flag, write-1-to-clear.
- 0x8+i DUTY[i]: [CW-1:0] shadow.
REQ-015 Register behaviour:
- Unused bits read 0; writes to them are ignored.
- Unmapped addresses read 0; writes to them have no effect.
- Reads of PERIOD, PRESCALE and DUTY return the shadow value.
REQ-016 Active copies of PERIOD, PRESCALE and all DUTY shadows SHALL load simultaneously:
- on the cycle the main counter wraps; or
- on every cycle while RUN=0.
No mid-period glitch is permitted.
REQ-017 Prescaler:
- pre counts 0..PRESCALE_act.
- tick asserts on the cycle pre==PRESCALE_act; pre returns to 0 on that cycle.
- PRESCALE=0 gives a tick on every cycle.
REQ-018 Main counter cnt (CW bits):
- advances on tick.
- When cnt==PERIOD_act at tick, cnt wraps to 0 in the same cycle and the active copies load.
- Period = (PERIOD+1)*(PRESCALE+1) clocks.
REQ-019 While RUN=0, pre and cnt SHALL be held at 0; after RUN is written 1, counting starts on the next cycle.
REQ-020 Raw compare: raw_i = RUN & CH_EN[i] & (cnt < DUTY_act[i]). Comparison is unsigned and CW bits wide.
REQ-021 Output: pwm_export[i] SHALL be registered as raw_i XOR INV, one clock after cnt.
REQ-022 Duty boundaries:
- DUTY=0 gives constant inactive.
- DUTY > PERIOD gives constant active.
- Inactive level is low when INV=0 and high when INV=1.
REQ-023 A disabled channel (RUN=0 or CH_EN[i]=0) SHALL drive INV.
REQ-024 WRAP SHALL set on each wrap. If set and write-1-clear coincide, set wins.
REQ-025 irq = WRAP & IRQ_EN, combinational from registers.
REQ-026 CH_EN and INV SHALL take effect immediately; they are not shadowed.
REQ-027 Simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-028 Reset SHALL clear the following to 0: CTRL, PERIOD (shadow and active), PRESCALE (shadow and active), CH_EN, all DUTY, pre, cnt, WRAP.
REQ-029 During and after reset, until the first write: pwm_export=0, irq=0, avs_readdata=0.
REQ-030 Reset assertion mid-period SHALL force all outputs to 0 asynchronously; no state survives reset.

Verification
REQ-031 Basic duty cycle:
- Stimulus: PERIOD=9, PRESCALE=0, DUTY[0]=3, CH_EN=1, RUN=1.
- Response: pwm_export[0] high exactly 3 of every 10 clocks, period 10 clocks.
REQ-032 Shadow update at wrap:
- Stimulus: with REQ-031 running, write DUTY[0]=7 when cnt=5.
- Response: the current period keeps 3 high clocks; the next period has 7 high clocks.
REQ-033 Duty and inversion boundaries:
- Stimulus: DUTY[1]=0, DUTY[2]=10, PERIOD=9, CH_EN=0x6.
- Response: ch1 constant 0, ch2 constant 1.
- With INV=1: ch1 constant 1, ch2 constant 0, ch3 (disabled) constant 1.
REQ-034 Prescaler and interrupt:
- Stimulus: PRESCALE=3, PERIOD=4, IRQ_EN=1.
- Response: wrap every 20 clocks; irq rises one clock after the wrap.
- Write 1 to STATUS: irq clears.
- Clear on the wrap cycle: irq stays 1.
REQ-035 Reset mid-operation:
- Stimulus: assert reset_reset_n=0 mid-period.
- Response: pwm_export=0 and irq=0 at once; after release, COUNT reads 0 and DUTY[0] reads 0.
REQ-036 Register access:
- Stimulus: read address 0x1F and address 0x6.
- Response: 0.
- Read-back of a PERIOD write arrives with latency 1.

Source files
------------

// File: rtl/user_gio_pwm_multi.sv
// Multi-channel PWM generator with an Avalon-MM register interface.
// A shared prescaler and period counter drive NCH compare channels.
// PERIOD, PRESCALE and DUTY are written into shadow registers and copied
// into the active set together, either at period wrap or continuously
// while stopped. This keeps the output free of mid-period glitches.
module user_gio_pwm_multi #(
  parameter int NCH = 18,
  parameter int CW  = 16,
  parameter int AW  = 5
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  input  logic [AW-1:0]  avs_address,
  input  logic           avs_write,
  input  logic [31:0]    avs_writedata,
  input  logic           avs_read,
  output logic [31:0]    avs_readdata,
  output logic           irq,
  output logic [NCH-1:0] pwm_export
);

  localparam logic [AW-1:0] ADDR_CTRL     = AW'(0);
  localparam logic [AW-1:0] ADDR_PERIOD   = AW'(1);
  localparam logic [AW-1:0] ADDR_PRESCALE = AW'(2);
  localparam logic [AW-1:0] ADDR_CH_EN    = AW'(3);
  localparam logic [AW-1:0] ADDR_COUNT    = AW'(4);
  localparam logic [AW-1:0] ADDR_STATUS   = AW'(5);
  localparam int            DUTY_BASE     = 8;

  // Control and configuration registers
  logic           run;
  logic           inv;
  logic           irq_en;
  logic [CW-1:0]  period_sh;
  logic [CW-1:0]  period_act;
  logic [15:0]    pre_sh;
  logic [15:0]    pre_act;
  logic [NCH-1:0] ch_en;
  logic [CW-1:0]  duty_sh  [NCH];
  logic [CW-1:0]  duty_act [NCH];

  // Timebase state
  logic [15:0]    pre;
  logic [CW-1:0]  cnt;
  logic           wrap_flag;

  logic           tick;
  logic           wrap;
  logic           load_act;
  logic [NCH-1:0] raw;
  logic [31:0]    rd_mux;

  logic           wr_ctrl;
  logic           wr_period;
  logic           wr_prescale;
  logic           wr_ch_en;
  logic           wr_status;
  logic [NCH-1:0] wr_duty;

  // Not every writedata bit lands in a register.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
  assign wr_period   = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_prescale = avs_write && (avs_address == ADDR_PRESCALE);
  assign wr_ch_en    = avs_write && (avs_address == ADDR_CH_EN);
  assign wr_status   = avs_write && (avs_address == ADDR_STATUS);

  // Per-channel DUTY write strobes
  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_duty[i] = avs_write && (avs_address == AW'(DUTY_BASE + i));
    end
  end

  // A tick ends each prescaler run. A wrap is a tick on the last count of the period.
  assign tick     = run && (pre == pre_act);
  assign wrap     = tick && (cnt == period_act);
  assign load_act = !run || wrap;

  // Host-writable control and shadow registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      run       <= 1'b0;
      inv       <= 1'b0;
      irq_en    <= 1'b0;
      period_sh <= '0;
      pre_sh    <= '0;
      ch_en     <= '0;
    end else begin
      if (wr_ctrl) begin
        run    <= avs_writedata[0];
        inv    <= avs_writedata[1];
        irq_en <= avs_writedata[2];
      end
      if (wr_period)   period_sh <= avs_writedata[CW-1:0];
      if (wr_prescale) pre_sh    <= avs_writedata[15:0];
      if (wr_ch_en)    ch_en     <= avs_writedata[NCH-1:0];
    end
  end

  // DUTY shadow registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_duty[i]) duty_sh[i] <= avs_writedata[CW-1:0];
      end
    end
  end

  // Active copies all load together, so a period never mixes old and new settings
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      period_act <= '0;
      pre_act    <= '0;
      for (int i = 0; i < NCH; i++) duty_act[i] <= '0;
    end else if (load_act) begin
      period_act <= period_sh;
      pre_act    <= pre_sh;
      for (int i = 0; i < NCH; i++) duty_act[i] <= duty_sh[i];
    end
  end

  // Prescaler and main period counter; both held at zero while stopped
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (!run) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= wrap ? '0 : cnt + CW'(1);
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Wrap status flag; a wrap in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wrap_flag <= 1'b0;
    end else if (wrap) begin
      wrap_flag <= 1'b1;
    end else if (wr_status && avs_writedata[0]) begin
      wrap_flag <= 1'b0;
    end
  end

  assign irq = wrap_flag & irq_en;

  // Raw compare for each channel. A duty above the period never matches,
  // so the channel stays active for the whole period.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NCH; i++) begin
      raw[i] = run && ch_en[i] && (cnt < duty_act[i]);
    end
  end

  // Registered outputs; INV is applied directly, without shadowing
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_export <= '0;
    end else begin
      pwm_export <= raw ^ {NCH{inv}};
    end
  end

  // Read data mux; unmapped addresses and unused bits return zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:     rd_mux = {29'd0, irq_en, inv, run};
      ADDR_PERIOD:   rd_mux = 32'(period_sh);
      ADDR_PRESCALE: rd_mux = 32'(pre_sh);
      ADDR_CH_EN:    rd_mux = 32'(ch_en);
      ADDR_COUNT:    rd_mux = 32'(cnt);
      ADDR_STATUS:   rd_mux = {31'd0, wrap_flag};
      default:       rd_mux = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (avs_address == AW'(DUTY_BASE + i)) rd_mux = 32'(duty_sh[i]);
    end
  end

  // Read data is captured on the read cycle, so a write to the same address
  // in that cycle does not show up until the next read
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else begin
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_user_gio_pwm_multi.sv
// Directed bench for user_gio_pwm_multi; default parameters (18 ch, 16-bit).
module tb_user_gio_pwm_multi;

  localparam int NCH = 18;
  localparam int CW  = 16;
  localparam int AW  = 5;

  logic           clk_clk = 1'b0;
  logic           reset_reset_n;
  logic [AW-1:0]  avs_address;
  logic           avs_write;
  logic [31:0]    avs_writedata;
  logic           avs_read;
  logic [31:0]    avs_readdata;
  logic           irq;
  logic [NCH-1:0] pwm_export;

  int checks = 0;
  int errors = 0;

  user_gio_pwm_multi #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pwm_export    (pwm_export)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk_clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk_clk);
    checks++;
    if (pwm_export !== '0 || irq !== 1'b0 || avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: pwm=%h irq=%b rdata=%h required 0/0/0", pwm_export, irq, avs_readdata);
    end
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    checks++;
    if (pwm_export !== '0 || irq !== 1'b0 || avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: pwm=%h irq=%b rdata=%h required 0/0/0", pwm_export, irq, avs_readdata);
    end
    rd(5'h0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h required 0", d); end
    rd(5'h4, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_count: got %h required 0", d); end
  endtask

  // PERIOD=9, DUTY0=3: sample k after the RUN edge is high when (k-1)%10 < 3
  task automatic test_basic_duty();
    int highs;
    logic exp;
    wr(5'h1, 32'd9);
    wr(5'h8, 32'd3);
    wr(5'h3, 32'd1);
    wr(5'h0, 32'd1);
    highs = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_clk);
      exp = (((k - 1) % 10) < 3);
      if (pwm_export[0]) highs++;
      checks++;
      if (pwm_export[0] !== exp) begin
        errors++;
        $display("FAIL basic_duty k=%0d: pwm0=%b required %b", k, pwm_export[0], exp);
      end
    end
    checks++;
    if (highs != 9) begin errors++; $display("FAIL basic_duty_count: highs=%0d required 9", highs); end
  endtask

  // Continues the basic run (sample index 31..). DUTY0=7 written while cnt=5.
  task automatic test_shadow_update();
    int highs_a, highs_b;
    logic exp;
    highs_a = 0;
    highs_b = 0;
    for (int k = 31; k <= 50; k++) begin
      @(negedge clk_clk);
      avs_write = 1'b0;
      exp = (k <= 40) ? (((k - 1) % 10) < 3) : (((k - 1) % 10) < 7);
      if (pwm_export[0]) begin
        if (k <= 40) highs_a++; else highs_b++;
      end
      checks++;
      if (pwm_export[0] !== exp) begin
        errors++;
        $display("FAIL shadow k=%0d: pwm0=%b required %b", k, pwm_export[0], exp);
      end
      if (k == 35) begin
        avs_address   = 5'h8;
        avs_writedata = 32'd7;
        avs_write     = 1'b1;
      end
    end
    checks++;
    if (highs_a != 3 || highs_b != 7) begin
      errors++;
      $display("FAIL shadow_counts: cur=%0d next=%0d required 3 and 7", highs_a, highs_b);
    end
  endtask

  task automatic test_boundaries();
    wr(5'h0, 32'd0);
    wr(5'h1, 32'd9);
    wr(5'h9, 32'd0);
    wr(5'hA, 32'd10);
    wr(5'h3, 32'h6);
    wr(5'h0, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_clk);
      checks++;
      if (pwm_export[1] !== 1'b0 || pwm_export[2] !== 1'b1) begin
        errors++;
        $display("FAIL bound k=%0d: ch1=%b ch2=%b required 0 1", k, pwm_export[1], pwm_export[2]);
      end
    end
    wr(5'h0, 32'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_clk);
      checks++;
      if (pwm_export[3:1] !== 3'b101) begin
        errors++;
        $display("FAIL bound_inv k=%0d: ch3..1=%b required 101", k, pwm_export[3:1]);
      end
    end
    wr(5'h0, 32'd2);
    @(negedge clk_clk);
    checks++;
    if (pwm_export !== {NCH{1'b1}}) begin
      errors++;
      $display("FAIL stopped_inv: pwm=%h required all ones", pwm_export);
    end
    wr(5'h0, 32'd0);
    @(negedge clk_clk);
    checks++;
    if (pwm_export !== '0) begin
      errors++;
      $display("FAIL stopped: pwm=%h required 0", pwm_export);
    end
  endtask

  // PRESCALE=3, PERIOD=4: wraps at edges 20 and 40 after RUN; irq visible at samples 20, 40
  task automatic test_prescale_irq();
    logic exp;
    logic [31:0] d;
    wr(5'h3, 32'd0);
    wr(5'h1, 32'd4);
    wr(5'h2, 32'd3);
    wr(5'h5, 32'd1);
    wr(5'h0, 32'd5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_start: irq=%b required 0", irq); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_clk);
      avs_write = 1'b0;
      exp = (k == 20) || (k == 40);
      checks++;
      if (irq !== exp) begin
        errors++;
        $display("FAIL irq k=%0d: irq=%b required %b", k, irq, exp);
      end
      if (k == 20 || k == 39) begin
        avs_address   = 5'h5;
        avs_writedata = 32'd1;
        avs_write     = 1'b1;
      end
    end
    wr(5'h0, 32'd1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: irq=%b required 0", irq); end
    rd(5'h5, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL status_read: got %h required 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(5'h0, 32'd7);
    wr(5'h3, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk_clk);
    checks++;
    if (irq !== 1'b1 || pwm_export[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: irq=%b ch1=%b required 1 1", irq, pwm_export[1]);
    end
    #3;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if (pwm_export !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pwm=%h irq=%b required 0 0", pwm_export, irq);
    end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    rd(5'h4, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL post_reset_count: got %h required 0", d); end
    rd(5'h8, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL post_reset_duty0: got %h required 0", d); end
    rd(5'h0, d);
    checks++;
    if (d !== 32'd0 || pwm_export !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ctrl: ctrl=%h pwm=%h irq=%b required 0", d, pwm_export, irq);
    end
  endtask

  task automatic test_register_access();
    logic [31:0] d;
    rd(5'h1F, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rd_1f: got %h required 0", d); end
    wr(5'h6, 32'hFFFF_FFFF);
    rd(5'h6, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rd_06: got %h required 0", d); end
    rd(5'd26, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rd_past_duty: got %h required 0", d); end
    wr(5'h1, 32'h1234_5678);
    @(negedge clk_clk);
    avs_address = 5'h1;
    avs_read    = 1'b1;
    checks++;
    if (avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL period_latency_early: got %h required 0", avs_readdata);
    end
    @(negedge clk_clk);
    avs_read = 1'b0;
    checks++;
    if (avs_readdata !== 32'h0000_5678) begin
      errors++;
      $display("FAIL period_latency: got %h required 00005678", avs_readdata);
    end
    @(negedge clk_clk);
    avs_address   = 5'h1;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    avs_writedata = 32'h22;
    @(negedge clk_clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    checks++;
    if (avs_readdata !== 32'h0000_5678) begin
      errors++;
      $display("FAIL rd_wr_same: got %h required 00005678", avs_readdata);
    end
    rd(5'h1, d);
    checks++;
    if (d !== 32'h22) begin errors++; $display("FAIL period_new: got %h required 22", d); end
    wr(5'h3, 32'hFFFF_FFFF);
    rd(5'h3, d);
    checks++;
    if (d !== 32'h0003_FFFF) begin errors++; $display("FAIL ch_en_mask: got %h required 3ffff", d); end
    wr(5'h2, 32'hFFFF_FFFF);
    rd(5'h2, d);
    checks++;
    if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL prescale_mask: got %h required ffff", d); end
    wr(5'h0, 32'hFFFF_FFFF);
    rd(5'h0, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL ctrl_mask: got %h required 7", d); end
    wr(5'h0, 32'd0);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    test_reset();
    test_basic_duty();
    test_shadow_update();
    test_boundaries();
    test_prescale_irq();
    test_reset_mid();
    test_register_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
